// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO pair.
//   MULT/MULTU/MADD/MSUB (and DIV/DIVU when built with HILO_DIV_EN) take
//   DATA_WIDTH cycles, one radix-2 step per edge. MTHI/MTLO complete at the
//   accepting edge. Hi/Lo change only when an operation completes.
//
//   Build option: define HILO_DIV_EN to include the restoring divider.
//   Without it, Op 110/111 are accepted as single-cycle no-ops.
//
// Ports
//   Clk    in   clock, rising edge
//   Reset  in   synchronous, active-low
//   Start  in   request, accepted only while Busy=0
//   Op     in   3-bit operation code (see op_t)
//   A, B   in   rs / rt operands
//   Hi, Lo out  architectural HI / LO
//   Busy   out  iterative operation in flight
//   Done   out  one-cycle pulse after Hi/Lo were written

module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo,
    output logic                  Busy,
    output logic                  Done
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000, OP_MULT = 3'b001, OP_MADD = 3'b010, OP_MSUB = 3'b011,
        OP_MTHI  = 3'b100, OP_MTLO = 3'b101, OP_DIVU = 3'b110, OP_DIV  = 3'b111
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0]       acc_q, acc_d;        // product, or {remainder, quotient}
    logic [2*W-1:0]       mcand_q, mcand_d;    // multiplicand magnitude, shifted left
    logic [W-1:0]         mplier_q, mplier_d;  // multiplier (shifted right) or divisor
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 neg_q, neg_d;        // negate product / quotient at the end

    // Operand magnitudes for the accepting edge.
    logic         signed_op, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;

    assign signed_op = !(Op == OP_MULTU || Op == OP_DIVU);
    assign a_neg     = signed_op & A[W-1];
    assign b_neg     = signed_op & B[W-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // One shift-add step and the signed final product it produces.
    logic [2*W-1:0] mul_acc_step, product;
    assign mul_acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign product      = neg_q ? -mul_acc_step : mul_acc_step;

`ifdef HILO_DIV_EN
    logic           neg_rem_q, neg_rem_d;      // remainder follows dividend sign
    logic [W:0]     div_part, div_trial;
    logic [2*W-1:0] div_acc_step;
    logic [W-1:0]   quot, rem;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; bit W of the trial is set when the divisor did not fit.
    // A zero divisor always fits, yielding all-ones quotient, rem = |A|.
    assign div_part     = acc_q[2*W-1:W-1];
    assign div_trial    = div_part - {1'b0, mplier_q};
    assign div_acc_step = div_trial[W] ? {div_part[W-1:0], acc_q[W-2:0], 1'b0}
                                       : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    assign quot         = div_acc_step[W-1:0];
    assign rem          = div_acc_step[2*W-1:W];
`endif

    always_comb begin
        // NOTE: every _d starts from its _q value so no branch can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
`ifdef HILO_DIV_EN
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef HILO_DIV_EN
                if (op_q == OP_DIVU || op_q == OP_DIV) begin
                    acc_d = div_acc_step;
                end else
`endif
                begin
                    acc_d    = mul_acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end

                // Last step: commit the whole result in one go.
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                    case (op_q)
                        OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + product;
                        OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - product;
`ifdef HILO_DIV_EN
                        OP_DIVU, OP_DIV: begin
                            lo_d = neg_q ? -quot : quot;
                            hi_d = neg_rem_q ? -rem : rem;
                        end
`endif
                        default: {hi_d, lo_d} = product;
                    endcase
                end
            end

            // IDLE and FINISH both have Busy=0, so both may accept.
            default: begin
                state_d = S_IDLE;
                if (Start) begin
                    op_d     = op_t'(Op);
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    cnt_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    case (op_t'(Op))
                        OP_MTHI: begin
                            hi_d    = A;
                            state_d = S_FINISH;
                        end
                        OP_MTLO: begin
                            lo_d    = A;
                            state_d = S_FINISH;
                        end
                        OP_DIVU, OP_DIV: begin
`ifdef HILO_DIV_EN
                            acc_d     = {{W{1'b0}}, a_mag};
                            // Divide by zero keeps the raw all-ones quotient.
                            neg_d     = (a_neg ^ b_neg) & (B != '0);
                            neg_rem_d = a_neg;
                            state_d   = S_RUN;
`else
                            state_d   = S_FINISH;
`endif
                        end
                        default: state_d = S_RUN;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignment only.
        if (!Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULTU;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
`ifdef HILO_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
`ifdef HILO_DIV_EN
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = (state_q == S_RUN);
    assign Done = (state_q == S_FINISH);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit (DATA_WIDTH=32). Expected Hi/Lo
// come from plain 64-bit arithmetic on the architectural rules; latency
// expectations depend on whether HILO_DIV_EN is defined for this build.

module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_hilo;   // reference {Hi, Lo}

    hilo_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_iterative(input logic [2:0] op);
`ifdef HILO_DIV_EN
        return op != 3'b100 && op != 3'b101;
`else
        return op[2] == 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
        longint sp;
        int     sa, sb;
        sp = longint'(signed'(a)) * longint'(signed'(b));
        sa = signed'(a);
        sb = signed'(b);
        case (op)
            3'b000: return {32'b0, a} * {32'b0, b};
            3'b001: return 64'(sp);
            3'b010: return hilo + 64'(sp);
            3'b011: return hilo - 64'(sp);
            3'b100: return {a, hilo[31:0]};
            3'b101: return {hilo[63:32], a};
`ifdef HILO_DIV_EN
            3'b110: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
`else
            default: return hilo;
`endif
        endcase
    endfunction

    // Present a request at a negedge, let the next rising edge accept it,
    // then scramble the inputs since they are don't-care after accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        m_hilo = model(op, a, b, m_hilo);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    // Called right after an accepting edge (plus any pre-counted busy cycles).
    // Returns at the negedge of the Done cycle.
    task automatic wait_done(input string tag, input logic [2:0] op, input int pre_busy);
        int busy_cnt;
        int t;
        busy_cnt = pre_busy;
        t = 0;
        @(negedge Clk);
        while (!Done && t < 200) begin
            if (Busy) busy_cnt++;
            t++;
            @(negedge Clk);
        end
        check({tag, " done"}, 64'(Done), 64'(1));
        check({tag, " busy_cycles"}, 64'(busy_cnt), is_iterative(op) ? 64'(32) : 64'(0));
        check({tag, " busy_at_done"}, 64'(Busy), 64'(0));
        check({tag, " hilo"}, {Hi, Lo}, m_hilo);
    endtask

    task automatic done_drops(input string tag);
        @(negedge Clk);
        check({tag, " done_one_cycle"}, 64'(Done), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag, op, 0);
    endtask

    initial begin
        int pre;
        int done_seen;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        // Reset for two cycles.
        m_hilo = '0;
        Start = 1'b1;
        Op    = 3'b100;
        A     = 32'hDEAD_BEEF;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check("reset hilo", {Hi, Lo}, 64'h0);
        check("reset busy", 64'(Busy), 64'(0));
        check("reset done", 64'(Done), 64'(0));
        Reset = 1'b1;

        // MTLO: single cycle.
        run_op("mtlo5", 3'b101, 32'd5, 32'd0);
        done_drops("mtlo5");

        // Signed and unsigned multiply.
        run_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3);
        check("mult exact", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        done_drops("mult");
        run_op("multu", 3'b000, 32'hFFFF_FFFE, 32'd3);
        check("multu exact", {Hi, Lo}, 64'h0000_0002_FFFF_FFFA);
        done_drops("multu");

        // MADD then MSUB chained in the Done cycle.
        run_op("mthi0", 3'b100, 32'd0, 32'd0);
        done_drops("mthi0");
        run_op("mtlo5b", 3'b101, 32'd5, 32'd0);
        done_drops("mtlo5b");
        run_op("madd", 3'b010, 32'hFFFF_FFFE, 32'd3);
        check("madd exact", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("msub_chain", 3'b011, 32'd1, 32'd1);
        check("msub exact", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        done_drops("msub_chain");

        // Divide corner cases (no-ops when the divider is not built).
        run_op("div_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2);
        done_drops("div_m7_2");
        run_op("divu_by0", 3'b110, 32'd7, 32'd0);
        done_drops("divu_by0");
        run_op("div_ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF);
        done_drops("div_ovf");
        run_op("div_neg_by0", 3'b111, 32'hFFFF_FFF0, 32'd0);
        done_drops("div_neg_by0");

        // Start while busy is ignored.
        issue(3'b001, 32'd2, 32'd3);
        pre = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            if (Busy) pre++;
        end
        Start = 1'b1;
        Op    = 3'b100;
        A     = 32'd9;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done("mult_ignore", 3'b001, pre);
        check("mult_ignore exact", {Hi, Lo}, 64'h0000_0000_0000_0006);
        done_drops("mult_ignore");

        // Reset mid-operation aborts; reset also wins over a same-edge Start.
        issue(3'b001, 32'h1234_5678, 32'h0000_0F0F);
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b1;
        Op    = 3'b100;
        A     = 32'h5555_AAAA;
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b1;
        m_hilo = '0;
        check("abort hilo", {Hi, Lo}, m_hilo);
        check("abort busy", 64'(Busy), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        check("abort no_done", 64'(done_seen), 64'(0));
        check("abort hilo_held", {Hi, Lo}, m_hilo);

        // Randomized operations against the reference model.
        for (int k = 0; k < 30; k++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            run_op("random", rop, ra, rb);
            if ($urandom_range(0, 2) != 0) done_drops("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO register pair, sitting beside the EX-stage ALU.
- Consumes the same A/B operands as the ALU.
- Executes MULT/MULTU/MADD/MSUB/DIV/DIVU over multiple cycles, and MTHI/MTLO in a single cycle.
- Drives Hi/Lo back to the ALU for MFHI/MFLO, and Busy to the hazard unit, which stalls the pipeline.

Parameters:
- DATA_WIDTH, 32, operand width; Hi and Lo are each DATA_WIDTH bits.
- CNT_WIDTH, 6, iteration counter width; must be at least clog2(DATA_WIDTH)+1.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  request; accepted only when Busy=0.
- Op  input  3  operation code: 000 MULTU, 001 MULT, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 DIVU, 111 DIV.
- A  input  DATA_WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source).
- B  input  DATA_WIDTH  rt operand (multiplier/divisor).
- Hi  output  DATA_WIDTH  architectural HI.
- Lo  output  DATA_WIDTH  architectural LO.
- Busy  output  1  iterative operation in flight.
- Done  output  1  one-cycle pulse: Hi/Lo just updated.

Behaviour:
- Reset: Reset=0 at a rising edge sets Hi=0, Lo=0, Busy=0, Done=0, counter=0 and state=IDLE. This aborts any in-flight operation; the partial result is discarded.
- States: IDLE, RUN, FINISH.
- Accept: Start=1 and Busy=0 at edge E0. A, B and Op are latched at E0; they are don't-care afterwards.
- MTHI/MTLO:
  - Hi (or Lo) := A at E0; the other register is unchanged.
  - Busy stays 0; Done=1 for the cycle after E0.
- Iterative ops (IDLE -> RUN at E0):
  - Busy=1 from E0 until the final edge.
  - Exactly DATA_WIDTH iterations, one per edge.
  - At edge E(DATA_WIDTH): Hi/Lo written with the final result, Busy->0, Done=1 for one cycle (FINISH), then IDLE.
  - Hi/Lo hold their old values throughout RUN; there are no partial updates.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2*DATA_WIDTH accumulator.
  - MULTU: unsigned operands.
  - MULT/MADD/MSUB: operands taken as absolute values; product negated when sign(A) xor sign(B).
  - MULT/MULTU: {Hi,Lo} := product.
  - MADD: {Hi,Lo} := {Hi,Lo} + signed product. MSUB: {Hi,Lo} := {Hi,Lo} - signed product.
  - All arithmetic is modulo 2^(2*DATA_WIDTH).
- Divide:
  - Restoring divider on magnitudes. Result: Lo := quotient, Hi := remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: still DATA_WIDTH cycles; Lo := all ones, Hi := A.
  - DIV most-negative / -1: Lo := 0x80000000, Hi := 0.
- Start while Busy=1: ignored; no state change and no queuing. The hazard unit must hold Start.
- Start in the Done cycle: accepted, because Busy=0. The new operation sees the just-written Hi/Lo, which matters for MADD/MSUB chaining.
- Reset wins over Start at the same edge.
- Unknown/reserved encodings: none, since all 8 codes are defined. With the optional feature disabled, codes 110/111 behave as described under Optional Feature below.

Optional Feature:
- Macro: HILO_DIV_EN.
- Defined: DIVU/DIV implemented as specified above.
- Undefined:
  - No divider datapath is synthesized.
  - Op 110/111 are accepted as no-ops: Hi/Lo unchanged, Busy stays 0, Done=1 for the cycle after accept.

Test Plan:
- Reset=0 for 2 cycles, then MTLO A=5 -> Lo=5, Hi=0, Busy never 1, Done pulses the cycle after accept.
- MULT A=0xFFFFFFFE, B=3 -> Busy=1 for 32 cycles; at E32 Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; Done=1 for exactly one cycle. MULTU with the same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
- Hi=0, Lo=5 (via MTLO), then MADD A=0xFFFFFFFE, B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF. Then MSUB A=1, B=1 issued in the Done cycle -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=7.
  - DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - Rerun these with HILO_DIV_EN undefined -> Hi/Lo unchanged, Done the cycle after accept.
- MULT A=2, B=3 started; Start=1 with MTHI A=9 at cycle 10 -> ignored, Hi/Lo=0/6 at E32. A second MULT with Reset=0 asserted at cycle 15 -> Hi=Lo=0, Busy=0, no Done pulse.
